// File: rtl/pgs_tsmac_stats_port_v2_0_pkg.sv
// rtl/pgs_tsmac_stats_port_v2_0_pkg.sv - shared defaults, control bit positions and decode types
package pgs_tsmac_stats_port_v2_0_pkg;

  localparam logic [7:0] DEF_BASE_ADX = 8'h15;
  localparam logic [7:0] DEF_CTRL_ADX = 8'h11;
  localparam int CLR_ALL_BIT = 0;
  localparam int RDCLR_BIT   = 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_CNT_LO,
    SEL_CNT_HI
  } sel_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pgs_tsmac_cnt_mux.sv
// rtl/pgs_tsmac_cnt_mux.sv - combinational NUM_CNT:1 counter selector returning low/high 32-bit words
module pgs_tsmac_cnt_mux #(
  parameter int NUM_CNT = 10,
  parameter int CNT_W   = 64,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic [IDX_W-1:0]         sel,
  output logic [31:0]              lo,
  output logic [31:0]              hi
);

  logic [CNT_W-1:0] word;
  logic [63:0]      ext;

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (sel == IDX_W'(i)) word = cnt_in[i*CNT_W +: CNT_W];
    end
  end

  // zero-extend so bits above CNT_W-1 always read as 0
  assign ext = 64'(word);
  assign lo  = ext[31:0];
  assign hi  = ext[63:32];

endmodule

// File: rtl/pgs_tsmac_stats_port_v2_0.sv
// rtl/pgs_tsmac_stats_port_v2_0.sv - host register port for statistics counters with snapshot and clear control
module pgs_tsmac_stats_port_v2_0
  import pgs_tsmac_stats_port_v2_0_pkg::*;
#(
  parameter int         NUM_CNT   = 10,
  parameter int         CNT_W     = 64,
  parameter logic [7:0] BASE_ADX  = DEF_BASE_ADX,
  parameter logic [7:0] CTRL_ADX  = DEF_CTRL_ADX,
  parameter bit         CLR_ON_RD = 1'b0,
  parameter int         TP        = 1
) (
  input  logic                     hstclk,
  input  logic                     hstrst,
  input  logic                     hstcsn,
  input  logic                     hstwrn,
  input  logic [7:0]               hstadx,
  input  logic [31:0]              hstidat,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  output logic [31:0]              hstodat,
  output logic                     hstoe,
  output logic [NUM_CNT-1:0]       cnt_clr
);

  localparam int IDX_W = idx_w(NUM_CNT);

  if (int'(BASE_ADX) + 2*NUM_CNT - 1 > 255) begin : g_bad_map
    $fatal(1, "counter address map exceeds 8'hFF");
  end
  if (TP < 0) begin : g_bad_tp
    $fatal(1, "TP must be non-negative");
  end

  logic             csn_q, armed, access;
  logic [31:0]      shadow, shadow_d, odat_d;
  logic [IDX_W-1:0] tag, tag_d, idx;
  logic             tag_vld, tag_vld_d, oe_d, rd_clr_en, rd_clr_en_d;
  logic [NUM_CNT-1:0] clr_d;
  logic [8:0]       off9;
  logic [31:0]      mux_lo, mux_hi;
  sel_e             sel;
  logic             unused_idat;

  assign unused_idat = ^hstidat[31:2];

  // armed stays low after reset until hstcsn has been seen high
  assign access = csn_q & armed & ~hstcsn;

  assign off9 = {1'b0, hstadx} - {1'b0, BASE_ADX};
  assign idx  = IDX_W'(off9[8:1]);

  always_comb begin
    sel = SEL_NONE;
    if (hstadx == CTRL_ADX) sel = SEL_CTRL;
    else if (hstadx >= BASE_ADX && off9 < 9'(2*NUM_CNT)) sel = off9[0] ? SEL_CNT_HI : SEL_CNT_LO;
  end

  pgs_tsmac_cnt_mux #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_mux (
    .cnt_in (cnt_in),
    .sel    (idx),
    .lo     (mux_lo),
    .hi     (mux_hi)
  );

  always_comb begin
    odat_d      = hstodat;
    oe_d        = 1'b0;
    clr_d       = '0;
    shadow_d    = shadow;
    tag_d       = tag;
    tag_vld_d   = tag_vld;
    rd_clr_en_d = rd_clr_en;
    if (access) begin
      if (hstwrn) begin
        oe_d = 1'b1;
        case (sel)
          SEL_CTRL: begin
            odat_d = '0;
            odat_d[RDCLR_BIT] = rd_clr_en;
          end
          SEL_CNT_LO: begin
            odat_d    = mux_lo;
            shadow_d  = mux_hi;
            tag_d     = idx;
            tag_vld_d = 1'b1;
            if (rd_clr_en) clr_d = NUM_CNT'(1) << idx;
          end
          SEL_CNT_HI: begin
            odat_d    = (tag_vld && tag == idx) ? shadow : mux_hi;
            tag_vld_d = 1'b0;
          end
          default: odat_d = '0;
        endcase
      end else if (sel == SEL_CTRL) begin
        rd_clr_en_d = hstidat[RDCLR_BIT];
        if (hstidat[CLR_ALL_BIT]) begin
          clr_d     = '1;
          tag_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge hstclk or posedge hstrst) begin
    if (hstrst) begin
      hstodat   <= '0;
      hstoe     <= 1'b0;
      cnt_clr   <= '0;
      shadow    <= '0;
      tag       <= '0;
      tag_vld   <= 1'b0;
      rd_clr_en <= CLR_ON_RD;
      csn_q     <= 1'b1;
      armed     <= 1'b0;
    end else begin
      hstodat   <= odat_d;
      hstoe     <= oe_d;
      cnt_clr   <= clr_d;
      shadow    <= shadow_d;
      tag       <= tag_d;
      tag_vld   <= tag_vld_d;
      rd_clr_en <= rd_clr_en_d;
      csn_q     <= hstcsn;
      armed     <= armed | hstcsn;
    end
  end

endmodule

// File: tb/tb_pgs_tsmac_stats_port_v2_0.sv
// tb/tb_pgs_tsmac_stats_port_v2_0.sv - directed self-checking bench for the statistics host port
module tb_pgs_tsmac_stats_port_v2_0;

  localparam int NC = 10;
  localparam int CW = 40;
  localparam logic [7:0] BASE = 8'h15;
  localparam logic [7:0] CTRL = 8'h11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csn = 1'b1;
  logic          wrn = 1'b1;
  logic [7:0]    adx = '0;
  logic [31:0]   idat = '0;
  logic [NC*CW-1:0] cnt_in = '0;
  logic [31:0]   odat;
  logic          oe;
  logic [NC-1:0] clr;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  pgs_tsmac_stats_port_v2_0 #(.NUM_CNT(NC), .CNT_W(CW)) dut (
    .hstclk  (clk),
    .hstrst  (rst),
    .hstcsn  (csn),
    .hstwrn  (wrn),
    .hstadx  (adx),
    .hstidat (idat),
    .cnt_in  (cnt_in),
    .hstodat (odat),
    .hstoe   (oe),
    .cnt_clr (clr)
  );

  task automatic set_cnt(input int i, input logic [CW-1:0] v);
    cnt_in[i*CW +: CW] = v;
  endtask

  // d/o/c sampled in cycle N+1; o2/c2 sampled one cycle later
  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic o,
                    output logic [NC-1:0] c, output logic o2, output logic [NC-1:0] c2);
    @(negedge clk); csn = 1'b0; wrn = 1'b1; adx = a;
    @(posedge clk); #1; d = odat; o = oe; c = clr; csn = 1'b1;
    @(posedge clk); #1; o2 = oe; c2 = clr;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v, input int hold,
                    output int n_all, output int n_any, output int n_oe);
    n_all = 0; n_any = 0; n_oe = 0;
    @(negedge clk); csn = 1'b0; wrn = 1'b0; adx = a; idat = v;
    for (int k = 0; k < hold + 2; k++) begin
      @(posedge clk); #1;
      if (clr == '1) n_all++;
      if (clr != '0) n_any++;
      if (oe) n_oe++;
      if (k == hold - 1) begin csn = 1'b1; wrn = 1'b1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; csn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2;
    @(posedge clk); #1;
    vec++; if (odat !== 32'h0) begin miss++; $display("FAIL reset_odat got %h want %h", odat, 32'h0); end
    vec++; if (oe !== 1'b0) begin miss++; $display("FAIL reset_oe got %b want 0", oe); end
    vec++; if (clr !== '0) begin miss++; $display("FAIL reset_clr got %h want 0", clr); end
    do_reset();
    rd(CTRL, d, o, c, o2, c2);
    vec++; if (d !== 32'h0 || o !== 1'b1) begin miss++; $display("FAIL reset_ctrl got %h/%b want 0/1", d, o); end
    vec++; if (o2 !== 1'b0) begin miss++; $display("FAIL oe_pulse got %b want 0", o2); end
  endtask

  task automatic test_untagged();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2;
    set_cnt(2, 40'h02_0000_0000);
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL untagged_hi1 got %h want %h", d, 32'h2); end
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL untagged_hi2 got %h want %h", d, 32'h2); end
    set_cnt(3, 40'h07_0000_0011);
    rd(BASE + 8'd6, d, o, c, o2, c2);
    vec++; if (d !== 32'h11) begin miss++; $display("FAIL lo3 got %h want %h", d, 32'h11); end
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL tag_mismatch got %h want %h", d, 32'h2); end
  endtask

  task automatic test_snapshot();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2;
    set_cnt(2, 40'h01_FFFF_FFFF);
    rd(BASE + 8'd4, d, o, c, o2, c2);
    vec++; if (d !== 32'hFFFF_FFFF || o !== 1'b1) begin miss++; $display("FAIL snap_lo got %h/%b want ffffffff/1", d, o); end
    vec++; if (c !== '0) begin miss++; $display("FAIL snap_noclr got %h want 0", c); end
    set_cnt(2, 40'h02_0000_0000);
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h1) begin miss++; $display("FAIL snap_hi got %h want %h", d, 32'h1); end
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL snap_hi_again got %h want %h", d, 32'h2); end
  endtask

  task automatic test_clr_on_read();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2; int na, ny, no;
    wr(CTRL, 32'h2, 1, na, ny, no);
    vec++; if (ny !== 0 || no !== 0) begin miss++; $display("FAIL ctrl_wr2 got clr %0d oe %0d want 0 0", ny, no); end
    rd(CTRL, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL ctrl_rd got %h want %h", d, 32'h2); end
    rd(BASE, d, o, c, o2, c2);
    vec++; if (c !== 10'h001 || o !== 1'b1) begin miss++; $display("FAIL rdclr got %h/%b want 001/1", c, o); end
    vec++; if (c2 !== 10'h000 || o2 !== 1'b0) begin miss++; $display("FAIL rdclr_len got %h/%b want 000/0", c2, o2); end
    rd(BASE + 8'd1, d, o, c, o2, c2);
    vec++; if (c !== 10'h000) begin miss++; $display("FAIL hi_noclr got %h want 000", c); end
  endtask

  task automatic test_clr_all();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2; int na, ny, no;
    set_cnt(2, 40'h04_0000_0009);
    rd(BASE + 8'd4, d, o, c, o2, c2);
    vec++; if (c !== 10'h004) begin miss++; $display("FAIL rdclr2 got %h want 004", c); end
    set_cnt(2, 40'h05_0000_0000);
    wr(CTRL, 32'h1, 5, na, ny, no);
    vec++; if (na !== 1 || ny !== 1 || no !== 0) begin miss++; $display("FAIL clr_all_long got %0d/%0d/%0d want 1/1/0", na, ny, no); end
    rd(BASE + 8'd5, d, o, c, o2, c2);
    vec++; if (d !== 32'h5) begin miss++; $display("FAIL clr_all_untag got %h want %h", d, 32'h5); end
    rd(CTRL, d, o, c, o2, c2);
    vec++; if (d !== 32'h0) begin miss++; $display("FAIL ctrl_after_1 got %h want %h", d, 32'h0); end
    wr(CTRL, 32'h3, 1, na, ny, no);
    vec++; if (na !== 1) begin miss++; $display("FAIL clr_all_3 got %0d want 1", na); end
    rd(CTRL, d, o, c, o2, c2);
    vec++; if (d !== 32'h2) begin miss++; $display("FAIL ctrl_after_3 got %h want %h", d, 32'h2); end
    wr(BASE, 32'hFFFF_FFFF, 1, na, ny, no);
    vec++; if (ny !== 0 || no !== 0) begin miss++; $display("FAIL cnt_wr_ignored got %0d/%0d want 0/0", ny, no); end
  endtask

  task automatic test_narrow_unmapped();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2;
    set_cnt(9, 40'hAB_1234_5678);
    set_cnt(8, 40'hFF_FFFF_FFFF);
    rd(BASE + 8'd18, d, o, c, o2, c2);
    vec++; if (d !== 32'h1234_5678 || c !== 10'h200) begin miss++; $display("FAIL c9_lo got %h/%h want 12345678/200", d, c); end
    rd(BASE + 8'd19, d, o, c, o2, c2);
    vec++; if (d !== 32'h0000_00AB) begin miss++; $display("FAIL c9_hi got %h want %h", d, 32'hAB); end
    rd(BASE + 8'd17, d, o, c, o2, c2);
    vec++; if (d !== 32'h0000_00FF) begin miss++; $display("FAIL c8_hi got %h want %h", d, 32'hFF); end
    rd(BASE + 8'd20, d, o, c, o2, c2);
    vec++; if (d !== 32'h0 || o !== 1'b1 || c !== '0) begin miss++; $display("FAIL unmapped_top got %h/%b/%h want 0/1/0", d, o, c); end
    rd(8'hFF, d, o, c, o2, c2);
    vec++; if (d !== 32'h0 || o !== 1'b1) begin miss++; $display("FAIL unmapped_ff got %h/%b want 0/1", d, o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic o, o2; logic [NC-1:0] c, c2; int n;
    set_cnt(0, 40'h00_DEAD_BEEF);
    rd(BASE, d, o, c, o2, c2);
    vec++; if (d !== 32'hDEAD_BEEF) begin miss++; $display("FAIL pre_reset got %h want deadbeef", d); end
    @(negedge clk); csn = 1'b0; wrn = 1'b1; adx = BASE;
    #1 rst = 1'b1;
    #1;
    vec++; if (oe !== 1'b0 || odat !== 32'h0 || clr !== '0) begin miss++; $display("FAIL mid_reset got %b/%h/%h want 0/0/0", oe, odat, clr); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; if (oe || clr != '0) n++; end
    vec++; if (n !== 0 || odat !== 32'h0) begin miss++; $display("FAIL held_csn got %0d/%h want 0/0", n, odat); end
    csn = 1'b1;
    @(posedge clk); #1;
    rd(BASE, d, o, c, o2, c2);
    vec++; if (d !== 32'hDEAD_BEEF || o !== 1'b1 || c !== '0) begin miss++; $display("FAIL post_reset got %h/%b/%h want deadbeef/1/0", d, o, c); end
  endtask

  initial begin
    test_reset();
    test_untagged();
    test_snapshot();
    test_clr_on_read();
    test_clr_all();
    test_narrow_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/pgs_tsmac_stats_port_v2_0.md
PGS_TSMAC_STATS_PORT_V2_0 -- requirements
Module: pgs_tsmac_stats_port_v2_0

Interface
Parameters (name, default, meaning):
REQ-001 NUM_CNT, 10, number of statistics counters (1..56).
REQ-002 CNT_W, 64, counter width in bits (33..64).
REQ-003 BASE_ADX, 8'h15, address of counter 0 low word; counter i low word = BASE_ADX+2i, high word = BASE_ADX+2i+1.
REQ-004 CTRL_ADX, 8'h11, control register address.
REQ-005 CLR_ON_RD, 0, reset value of the runtime clear-on-read enable.
REQ-006 TP, 1, simulation delay on all register assignments.
Ports (name, direction, width, meaning):
REQ-007 hstclk  in  1  host clock; the block's only clock.
REQ-008 hstrst  in  1  asynchronous, active-high reset.
REQ-009 hstcsn  in  1  host chip select, active low.
REQ-010 hstwrn  in  1  1 = read, 0 = write.
REQ-011 hstadx  in  8  host address.
REQ-012 hstidat  in  32  host write data.
REQ-013 cnt_in  in  NUM_CNT*CNT_W  live counter values; counter i occupies bits [i*CNT_W +: CNT_W].
REQ-014 hstodat  out  32  registered read data.
REQ-015 hstoe  out  1  read-data valid; one-cycle pulse.
REQ-016 cnt_clr  out  NUM_CNT  per-counter clear pulses to the counter owners.

Function
REQ-017 An access is the first cycle of hstcsn low (falling-edge detect on registered hstcsn). Holding hstcsn low produces exactly one access; a new access needs hstcsn high for at least one cycle.
REQ-018 Read latency is 1 cycle. In cycle N+1 after a read access at cycle N, hstodat is valid and hstoe = 1. Otherwise hstoe = 0 and hstodat holds its last value.
REQ-019 Low-word read of counter i:
- hstodat = cnt_in[i] bits [31:0].
- In the same edge, shadow <= cnt_in[i] bits [CNT_W-1:32], zero-extended to 32 bits.
- In the same edge, tag <= i and tag_vld <= 1.
REQ-020 High-word read of counter i:
- If tag_vld and tag == i, hstodat = shadow.
- Otherwise hstodat = live upper bits of counter i, zero-extended.
- In both cases tag_vld <= 0.
REQ-021 Control register at CTRL_ADX:
- bit0 clr_all: write-1 self-clearing.
- bit1 rd_clr_en: read/write.
- Read returns {30'b0, rd_clr_en, 1'b0}.
REQ-022 When rd_clr_en = 1, a low-word read of counter i asserts cnt_clr[i] for exactly one cycle (cycle N+1), coincident with hstoe.
REQ-023 A write of 1 to clr_all asserts cnt_clr = all ones for one cycle (cycle N+1), and also sets tag_vld <= 0.
REQ-024 Writes to counter addresses and to unmapped addresses are ignored.
REQ-025 Reads of unmapped addresses (including BASE_ADX+2*NUM_CNT and above) return 32'h0 and still pulse hstoe.
REQ-026 Address decode is exact 8-bit compare. BASE_ADX+2*NUM_CNT-1 must not exceed 8'hFF; this is checked at elaboration, and a violation is a fatal error.
REQ-027 If a clr_all write and a clear-on-read fall in the same cycle, cnt_clr is all ones; the shadow contents are still captured.
REQ-028 Upper-word arithmetic: bits above CNT_W-1 read as 0. No sign extension.

Reset
REQ-029 On hstrst assertion, immediately:
- hstodat = 0, hstoe = 0, cnt_clr = 0.
- shadow = 0, tag = 0, tag_vld = 0.
- rd_clr_en = CLR_ON_RD.
- edge-detect register = 1 (no access pending).
REQ-030 An access in progress when hstrst asserts is abandoned: no hstoe and no cnt_clr after release.
REQ-031 hstcsn already low when hstrst deasserts is not an access until hstcsn has gone high and then low again.

Structure
REQ-032 Shared header pgs_tsmac_stats_defs.vh holds the default BASE_ADX and CTRL_ADX and the control bit positions (CLR_ALL_BIT=0, RDCLR_BIT=1).
REQ-033 One sub-module, pgs_tsmac_cnt_mux, is a parametrised combinational NUM_CNT:1 selector returning the low and high 32-bit words of counter i.
REQ-034 All state lives in the top module.

Verification
REQ-035 Snapshot: counter 2 = 64'h0000_0001_FFFF_FFFF, read BASE+4. Counter then increments to 64'h0000_0002_0000_0000; read BASE+5 -> 32'h0000_0001.
REQ-036 Untagged high read: read BASE+5 with no preceding low read after reset -> live value 32'h0000_0002. Then read BASE+5 again -> still the live value (tag_vld = 0).
REQ-037 Clear-on-read: write CTRL_ADX = 32'h2, read BASE+0 -> cnt_clr = 10'b00_0000_0001 for one cycle, coincident with hstoe.
REQ-038 clr_all plus long chip select: hold hstcsn low 5 cycles while writing 32'h1 to CTRL_ADX -> exactly one cycle of cnt_clr = 10'h3FF. A read of CTRL_ADX then returns rd_clr_en in bit1 and bit0 = 0.
REQ-039 Narrow/unmapped: with CNT_W = 40, counter 9 = 40'hAB_1234_5678, read BASE+18 then BASE+19 -> 32'h1234_5678, then 32'h0000_00AB. A read of BASE+20 -> 32'h0 with an hstoe pulse.
REQ-040 Reset mid-access: assert hstrst in the cycle after a read access -> hstoe stays 0 and hstodat = 0. Holding hstcsn low through reset release produces no access.
